// File: rtl/serial_negate_sched.sv
// serial_negate_sched: round-robin two-requester front end for a bit-serial two's-complement negator.
// Define SNEG_OVF_FLAG_EN to add rsp_ovf, flagging the unrepresentable most-negative operand.
module serial_negate_sched #(
  parameter int WIDTH = 8
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
`ifdef SNEG_OVF_FLAG_EN
  ,
  output logic             rsp_ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             id_q, id_d;
  logic             rr_q, rr_d;
  logic             grant;
  logic             b;
  logic             last;
  logic             idle;

  // Single valid wins outright; a tie goes to the round-robin pointer.
  always_comb begin
    grant = rr_q;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
  end

  assign idle       = (state_q == IDLE) && !r;
  assign req0_ready = idle && req0_valid && !grant;
  assign req1_ready = idle && req1_valid && grant;

  assign b    = sreg_q[0];
  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    id_d    = id_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          sreg_d  = req1_ready ? req1_data : req0_data;
          id_d    = req1_ready;
          rr_d    = !req1_ready;
          seen_d  = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Invert every bit above the lowest set bit.
        res_d  = {b ^ seen_q, res_q[WIDTH-1:1]};
        sreg_d = sreg_q >> 1;
        seen_d = seen_q | b;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      id_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = res_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

`ifdef SNEG_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  // Only a lone MSB set bit leaves seen_one clear until the final shift.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && (req0_ready || req1_ready)) begin
      ovf_d = 1'b0;
    end else if (state_q == SHIFT && last) begin
      ovf_d = b && !seen_q;
    end
  end

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign rsp_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_negate_sched.sv
// tb_serial_negate_sched: directed scenarios plus a randomized sweep
// checked against a transaction-level negation model.
module tb_serial_negate_sched;

  localparam int W = 8;

  logic         t_clk = 1'b0;
  logic         r;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_id;
  logic         busy;
`ifdef SNEG_OVF_FLAG_EN
  logic         rsp_ovf;
  logic         last_ovf;
`endif

  int checks = 0;
  int passed = 0;

  always #5 t_clk = ~t_clk;

  serial_negate_sched #(.WIDTH(W)) dut (
    .t_clk      (t_clk),
    .r          (r),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
`ifdef SNEG_OVF_FLAG_EN
    ,
    .rsp_ovf    (rsp_ovf)
`endif
  );

  function automatic logic [W-1:0] neg(input logic [W-1:0] x);
    int v;
    v = (256 - int'(x)) % 256;
    return v[W-1:0];
  endfunction

  task automatic do_reset;
    @(negedge t_clk);
    r = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge t_clk);
    r = 1'b0;
  endtask

  // Issue one operand with rsp_ready held high; report latency and result.
  task automatic send(input logic id, input logic [W-1:0] d,
                      output logic acc, output int lat,
                      output logic [W-1:0] rd, output logic rid);
    @(negedge t_clk);
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1;
      req1_data = d;
    end else begin
      req0_valid = 1'b1;
      req0_data = d;
    end
    #1;
    acc = id ? req1_ready : req0_ready;
    @(posedge t_clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = W'($urandom);
    req1_data = W'($urandom);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge t_clk);
      #1;
      lat++;
    end
    rd = rsp_data;
    rid = rsp_id;
`ifdef SNEG_OVF_FLAG_EN
    last_ovf = rsp_ovf;
`endif
    @(posedge t_clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge t_clk);
    r = 1'b1;
    req0_valid = 1'b1;
    req0_data = 8'h12;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge t_clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
    else passed++;
    checks++;
    if (rsp_data !== 8'h00) $display("FAIL reset_rsp_data: got %h want 00", rsp_data);
    else passed++;
    checks++;
    if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id: got %b want 0", rsp_id);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else passed++;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
      $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
    else passed++;
`ifdef SNEG_OVF_FLAG_EN
    checks++;
    if (rsp_ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", rsp_ovf);
    else passed++;
`endif
    @(negedge t_clk);
    req0_valid = 1'b0;
    r = 1'b0;
  endtask

  task automatic test_single;
    logic acc, rid;
    int lat;
    logic [W-1:0] rd;
    send(1'b0, 8'h05, acc, lat, rd, rid);
    checks++;
    if (acc !== 1'b1) $display("FAIL single_accept: got %b want 1", acc);
    else passed++;
    checks++;
    if (lat != W) $display("FAIL single_latency: got %0d want %0d", lat, W);
    else passed++;
    checks++;
    if (rd !== 8'hFB) $display("FAIL single_data: got %h want fb", rd);
    else passed++;
    checks++;
    if (rid !== 1'b0) $display("FAIL single_id: got %b want 0", rid);
    else passed++;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_idle_after: got valid=%b busy=%b want 0 0", rsp_valid, busy);
    else passed++;
  endtask

  task automatic test_boundaries;
    logic acc, rid;
    int lat;
    logic [W-1:0] rd;
    send(1'b1, 8'h00, acc, lat, rd, rid);
    checks++;
    if (rd !== 8'h00 || rid !== 1'b1)
      $display("FAIL zero_operand: got %h id %b want 00 id 1", rd, rid);
    else passed++;
`ifdef SNEG_OVF_FLAG_EN
    checks++;
    if (last_ovf !== 1'b0) $display("FAIL zero_ovf: got %b want 0", last_ovf);
    else passed++;
`endif
    send(1'b1, 8'h80, acc, lat, rd, rid);
    checks++;
    if (rd !== 8'h80 || rid !== 1'b1)
      $display("FAIL min_operand: got %h id %b want 80 id 1", rd, rid);
    else passed++;
`ifdef SNEG_OVF_FLAG_EN
    checks++;
    if (last_ovf !== 1'b1) $display("FAIL min_ovf: got %b want 1", last_ovf);
    else passed++;
`endif
  endtask

  task automatic test_contention;
    logic [W-1:0] gd[$];
    logic         gi[$];
    logic [W-1:0] ed[3];
    logic         ei[3];
    int n;
    ed = '{8'hFF, 8'hFE, 8'hFF};
    ei = '{1'b0, 1'b1, 1'b0};
    do_reset();
    @(negedge t_clk);
    req0_valid = 1'b1;
    req0_data = 8'h01;
    req1_valid = 1'b1;
    req1_data = 8'h02;
    rsp_ready = 1'b1;
    n = 0;
    while (gd.size() < 3 && n < 100) begin
      #1;
      checks++;
      if (req0_ready && req1_ready) $display("FAIL both_ready: got 11 want at most one");
      else passed++;
      if (rsp_valid && rsp_ready) begin
        gd.push_back(rsp_data);
        gi.push_back(rsp_id);
      end
      @(negedge t_clk);
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (gd.size() != 3) $display("FAIL contention_count: got %0d want 3", gd.size());
    else passed++;
    for (int i = 0; i < gd.size(); i++) begin
      checks++;
      if (gd[i] !== ed[i] || gi[i] !== ei[i])
        $display("FAIL contention_%0d: got %h id %b want %h id %b", i, gd[i], gi[i], ed[i], ei[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure;
    int n;
    @(negedge t_clk);
    req0_valid = 1'b1;
    req0_data = 8'h3C;
    rsp_ready = 1'b0;
    @(posedge t_clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_data = 8'h11;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(posedge t_clk);
      #1;
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge t_clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hC4 || rsp_id !== 1'b0)
        $display("FAIL bp_hold_%0d: got v%b %h id %b want v1 c4 id 0", k, rsp_valid, rsp_data, rsp_id);
      else passed++;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
        $display("FAIL bp_ready_%0d: got %b%b want 00", k, req0_ready, req1_ready);
      else passed++;
    end
    @(negedge t_clk);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b0) $display("FAIL bp_ready_hs: got %b want 0", req1_ready);
    else passed++;
    @(posedge t_clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1)
      $display("FAIL bp_after_hs: got valid=%b ready1=%b want 0 1", rsp_valid, req1_ready);
    else passed++;
    @(posedge t_clk);
    #1;
    req1_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL bp_next_accept: got busy %b want 1", busy);
    else passed++;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(posedge t_clk);
      #1;
      n++;
    end
    checks++;
    if (rsp_data !== 8'hEF || rsp_id !== 1'b1)
      $display("FAIL bp_second: got %h id %b want ef id 1", rsp_data, rsp_id);
    else passed++;
    @(posedge t_clk);
    #1;
  endtask

  task automatic test_reset_mid;
    logic acc, rid;
    int lat;
    logic [W-1:0] rd;
    @(negedge t_clk);
    req0_valid = 1'b1;
    req0_data = 8'h33;
    rsp_ready = 1'b1;
    @(posedge t_clk);
    #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge t_clk);
    #1;
    r = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 8'h00)
      $display("FAIL mid_reset: got v%b busy%b %h want v0 busy0 00", rsp_valid, busy, rsp_data);
    else passed++;
    @(negedge t_clk);
    r = 1'b0;
    send(1'b1, 8'h7F, acc, lat, rd, rid);
    checks++;
    if (acc !== 1'b1 || lat != W || rd !== 8'h81 || rid !== 1'b1)
      $display("FAIL post_reset: got acc%b lat%0d %h id %b want acc1 lat%0d 81 id 1",
               acc, lat, rd, rid, W);
    else passed++;
  endtask

  task automatic test_random;
    int ph, left, acc_n, cyc;
    logic rr, v0, v1, e0, e1, m_id;
    logic [W-1:0] m_op;
    do_reset();
    ph = 0;
    left = 0;
    acc_n = 0;
    cyc = 0;
    rr = 1'b0;
    m_id = 1'b0;
    m_op = '0;
    while ((acc_n < 1000 || ph != 0) && cyc < 60000) begin
      @(negedge t_clk);
      v0 = (acc_n < 1000) && ($urandom_range(0, 1) == 1);
      v1 = (acc_n < 1000) && ($urandom_range(0, 1) == 1);
      req0_valid = v0;
      req1_valid = v1;
      req0_data = W'($urandom);
      req1_data = W'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      e0 = (ph == 0) && v0 && (!v1 || !rr);
      e1 = (ph == 0) && v1 && (!v0 || rr);
      checks++;
      if (req0_ready !== e0 || req1_ready !== e1)
        $display("FAIL rand_ready c%0d: got %b%b want %b%b", cyc, req0_ready, req1_ready, e0, e1);
      else passed++;
      checks++;
      if (rsp_valid !== (ph == 2)) $display("FAIL rand_valid c%0d: got %b want %b", cyc, rsp_valid, ph == 2);
      else passed++;
      if (ph == 2) begin
        checks++;
        if (rsp_data !== neg(m_op) || rsp_id !== m_id)
          $display("FAIL rand_rsp c%0d: got %h id %b want %h id %b", cyc, rsp_data, rsp_id, neg(m_op), m_id);
        else passed++;
`ifdef SNEG_OVF_FLAG_EN
        checks++;
        if (rsp_ovf !== (m_op == 8'h80))
          $display("FAIL rand_ovf c%0d: got %b want %b", cyc, rsp_ovf, m_op == 8'h80);
        else passed++;
`endif
      end
      @(posedge t_clk);
      cyc++;
      if (ph == 0) begin
        if (e0 || e1) begin
          m_id = e1;
          m_op = e1 ? req1_data : req0_data;
          rr = !e1;
          left = W;
          ph = 1;
          acc_n++;
        end
      end else if (ph == 1) begin
        left--;
        if (left == 0) ph = 2;
      end else if (rsp_ready) begin
        ph = 0;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (acc_n < 1000 || ph != 0)
      $display("FAIL rand_timeout: got %0d accepts want 1000", acc_n);
    else passed++;
  endtask

  initial begin
    r = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = '0;
    req1_data = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_boundaries();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
